// File: rtl/hci_ts_mem_bank_adapter_pkg.sv
// Shared types and constants for the TCDM bank adapter with test-and-set support.
package hci_ts_mem_bank_adapter_pkg;

    typedef enum logic {
        HCI_TS_IDLE,
        HCI_TS_WB
    } hci_ts_state_e;

    // Write-back fill pattern, sliced to the data width at the point of use.
    localparam int unsigned               HCI_TS_MAX_DW   = 1024;
    localparam logic [HCI_TS_MAX_DW-1:0]  HCI_TS_WB_VALUE = '1;

endpackage

// File: rtl/hci_ts_mem_bank_adapter_if.sv
// Interconnect-side request/response bundle of one memory bank port.
interface hci_ts_mem_bank_adapter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned BW = 8,
    parameter int unsigned IW = 20
);
    logic              req_i;
    logic              gnt_o;
    logic [AW-1:0]     add_i;
    logic              wen_i;
    logic [DW-1:0]     data_i;
    logic [DW/BW-1:0]  be_i;
    logic [IW-1:0]     id_i;
    logic              ts_set_i;
    logic              r_valid_o;
    logic [DW-1:0]     r_data_o;
    logic [IW-1:0]     r_id_o;

    modport master (
        output req_i, add_i, wen_i, data_i, be_i, id_i, ts_set_i,
        input  gnt_o, r_valid_o, r_data_o, r_id_o
    );

    modport slave (
        input  req_i, add_i, wen_i, data_i, be_i, id_i, ts_set_i,
        output gnt_o, r_valid_o, r_data_o, r_id_o
    );
endinterface

// File: rtl/hci_ts_mem_bank_adapter.sv
// Per-bank adapter between a TCDM interconnect port and a single-port SRAM, with test-and-set.
// Optional output register stage: define HCI_TS_BANK_OUT_REG_EN (response latency 2 instead of 1).
//
// state       | meaning
// ------------+-----------------------------------------------------------
// HCI_TS_IDLE | grant every request, SRAM driven straight from the request
// HCI_TS_WB   | one-cycle all-ones write-back of a test-and-set, no grant
module hci_ts_mem_bank_adapter
    import hci_ts_mem_bank_adapter_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned BW = 8,
    parameter int unsigned IW = 20
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    hci_ts_mem_bank_adapter_if.slave bus,
    output logic                   sram_req_o,
    output logic                   sram_we_o,
    output logic [AW-3:0]          sram_add_o,
    output logic [DW-1:0]          sram_wdata_o,
    output logic [DW/BW-1:0]       sram_be_o,
    input  logic [DW-1:0]          sram_rdata_i
);

    hci_ts_state_e   state_q, state_d;
    logic [AW-3:0]   ts_add_q;
    logic            ts_latch;
    logic            gnt;
    logic            grant;
    logic            r_valid_q;
    logic [IW-1:0]   r_id_q;
    logic            unused_add;

    assign unused_add = ^bus.add_i[1:0];
    assign grant      = bus.req_i & gnt;
    assign bus.gnt_o  = gnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= HCI_TS_IDLE;
            ts_add_q  <= '0;
            r_valid_q <= 1'b0;
            r_id_q    <= '0;
        end else begin
            state_q   <= state_d;
            r_valid_q <= grant;
            if (ts_latch) ts_add_q <= bus.add_i[AW-1:2];
            if (grant)    r_id_q   <= bus.id_i;
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt          = 1'b0;
        ts_latch     = 1'b0;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_add_o   = ts_add_q;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        case (state_q)
            HCI_TS_IDLE: begin
                gnt          = 1'b1;
                sram_req_o   = bus.req_i;
                sram_we_o    = ~bus.wen_i;
                sram_add_o   = bus.add_i[AW-1:2];
                sram_wdata_o = bus.data_i;
                sram_be_o    = bus.be_i;
                if (bus.req_i && bus.ts_set_i && bus.wen_i) begin
                    ts_latch = 1'b1;
                    state_d  = HCI_TS_WB;
                end
            end
            HCI_TS_WB: begin
                // A reset landing in this cycle must not let the write-back reach the SRAM.
                sram_req_o   = ~rst_i;
                sram_we_o    = ~rst_i;
                sram_add_o   = ts_add_q;
                sram_wdata_o = HCI_TS_WB_VALUE[DW-1:0];
                sram_be_o    = '1;
                state_d      = HCI_TS_IDLE;
            end
            default: state_d = HCI_TS_IDLE;
        endcase
    end

`ifdef HCI_TS_BANK_OUT_REG_EN
    logic            out_valid_q;
    logic [DW-1:0]   out_data_q;
    logic [IW-1:0]   out_id_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            out_valid_q <= r_valid_q;
            out_data_q  <= sram_rdata_i;
            out_id_q    <= r_id_q;
        end
    end

    assign bus.r_valid_o = out_valid_q;
    assign bus.r_data_o  = out_data_q;
    assign bus.r_id_o    = out_id_q;
`else
    assign bus.r_valid_o = r_valid_q;
    assign bus.r_data_o  = sram_rdata_i;
    assign bus.r_id_o    = r_id_q;
`endif

endmodule

// File: tb/tb_hci_ts_mem_bank_adapter.sv
// Self-checking bench for hci_ts_mem_bank_adapter: directed scenarios plus a randomized stream.
module tb_hci_ts_mem_bank_adapter;

    localparam int unsigned AW = 32, DW = 32, BW = 8, IW = 20;
`ifdef HCI_TS_BANK_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hci_ts_mem_bank_adapter_if #(.AW(AW), .DW(DW), .BW(BW), .IW(IW)) bus ();

    logic            sram_req, sram_we;
    logic [AW-3:0]   sram_add;
    logic [DW-1:0]   sram_wdata, sram_rdata;
    logic [DW/BW-1:0] sram_be;

    hci_ts_mem_bank_adapter #(.AW(AW), .DW(DW), .BW(BW), .IW(IW)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus),
        .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_add_o(sram_add),
        .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
    );

    // SRAM macro model: registered read, byte-masked write.
    logic [31:0] sram_mem [int unsigned];
    always @(posedge clk) begin
        logic [31:0] w;
        if (sram_req === 1'b1) begin
            w = sram_mem.exists(sram_add) ? sram_mem[sram_add] : 32'h0;
            if (sram_we === 1'b1) begin
                for (int b = 0; b < 4; b++) if (sram_be[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
                sram_mem[sram_add] = w;
            end else begin
                sram_rdata <= w;
            end
        end
    end

    int checks = 0, errors = 0;

    // Reference model: memory contents and in-flight responses.
    typedef struct { bit v; bit rd; logic [IW-1:0] id; logic [31:0] d; } rsp_t;
    rsp_t        pipe [LAT];
    logic [31:0] mem_m [int unsigned];
    bit          mon_en = 1'b0;
    bit          ts_pend = 1'b0;
    logic [29:0] ts_wa;

    function automatic logic [31:0] mem_rd(input logic [29:0] a);
        return mem_m.exists(a) ? mem_m[a] : 32'h0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(negedge clk) begin
        rsp_t        nr;
        bit          in_wb;
        logic [29:0] wa;
        logic [31:0] old;
        if (mon_en) begin
            checks++;
            if (bus.gnt_o !== !ts_pend) begin
                errors++; $display("FAIL mon_gnt t=%0t: got %b expected %b", $time, bus.gnt_o, !ts_pend);
            end
            checks++;
            if (bus.r_valid_o !== pipe[LAT-1].v) begin
                errors++; $display("FAIL mon_r_valid t=%0t: got %b expected %b", $time, bus.r_valid_o, pipe[LAT-1].v);
            end
            if (pipe[LAT-1].v) begin
                checks++;
                if (bus.r_id_o !== pipe[LAT-1].id) begin
                    errors++; $display("FAIL mon_r_id t=%0t: got %h expected %h", $time, bus.r_id_o, pipe[LAT-1].id);
                end
                if (pipe[LAT-1].rd) begin
                    checks++;
                    if (bus.r_data_o !== pipe[LAT-1].d) begin
                        errors++; $display("FAIL mon_r_data t=%0t: got %h expected %h", $time, bus.r_data_o, pipe[LAT-1].d);
                    end
                end
            end
        end
        in_wb = ts_pend;
        if (ts_pend) begin
            if (!rst) mem_m[ts_wa] = 32'hFFFF_FFFF;
            ts_pend = 1'b0;
        end
        nr = '{v: 1'b0, rd: 1'b0, id: '0, d: '0};
        if (!rst && !in_wb && bus.req_i) begin
            wa    = bus.add_i[31:2];
            old   = mem_rd(wa);
            nr.v  = 1'b1;
            nr.rd = bus.wen_i;
            nr.id = bus.id_i;
            nr.d  = old;
            if (!bus.wen_i) mem_m[wa] = merge(old, bus.data_i, bus.be_i);
            else if (bus.ts_set_i) begin ts_pend = 1'b1; ts_wa = wa; end
        end
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] = '{v: 1'b0, rd: 1'b0, id: '0, d: '0};
        end else begin
            for (int i = LAT-1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = nr;
        end
    end

    // Per-cycle stimulus sequence and recorded observations.
    typedef struct { bit rst; bit req; bit wen; bit ts; logic [31:0] add; logic [31:0] data; logic [3:0] be; logic [IW-1:0] id; } req_t;
    req_t        seq [$];
    logic        o_gnt [$], o_valid [$], o_sw [$];
    logic [31:0] o_data [$];
    logic [IW-1:0] o_id [$];
    logic [AW-3:0] o_add [$];

    function automatic req_t mk(input bit req, input bit wen, input bit ts, input logic [31:0] add,
                                input logic [31:0] data, input logic [3:0] be, input logic [IW-1:0] id);
        req_t e;
        e = '{rst: 1'b0, req: req, wen: wen, ts: ts, add: add, data: data, be: be, id: id};
        return e;
    endfunction

    task automatic drive(input req_t e);
        rst          = e.rst;
        bus.req_i    = e.req;
        bus.wen_i    = e.wen;
        bus.ts_set_i = e.ts;
        bus.add_i    = e.add;
        bus.data_i   = e.data;
        bus.be_i     = e.be;
        bus.id_i     = e.id;
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) seq.push_back(mk(0, 1, 0, 0, 0, 0, 0));
    endtask

    task automatic run_seq();
        o_gnt.delete(); o_valid.delete(); o_sw.delete(); o_data.delete(); o_id.delete(); o_add.delete();
        foreach (seq[c]) begin
            @(posedge clk); #1;
            drive(seq[c]);
            @(negedge clk);
            o_gnt.push_back(bus.gnt_o);
            o_valid.push_back(bus.r_valid_o);
            o_data.push_back(bus.r_data_o);
            o_id.push_back(bus.r_id_o);
            o_sw.push_back(sram_req & sram_we);
            o_add.push_back(sram_add);
        end
        seq.delete();
    endtask

    task automatic test_reset();
        drive(mk(0, 1, 0, 0, 0, 0, 0));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.gnt_o !== 1'b1)     begin errors++; $display("FAIL reset_gnt: got %b expected 1", bus.gnt_o); end
        checks++; if (bus.r_valid_o !== 1'b0) begin errors++; $display("FAIL reset_r_valid: got %b expected 0", bus.r_valid_o); end
        checks++; if (bus.r_id_o !== '0)      begin errors++; $display("FAIL reset_r_id: got %h expected 0", bus.r_id_o); end
        checks++; if (sram_req !== 1'b0)      begin errors++; $display("FAIL reset_sram_req: got %b expected 0", sram_req); end
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_write_read();
        seq.push_back(mk(1, 0, 0, 32'h40, 32'hCAFE0001, 4'hF, 20'd3));
        seq.push_back(mk(1, 1, 0, 32'h40, 32'h0, 4'hF, 20'd7));
        add_idle(4);
        run_seq();
        checks++; if (o_gnt[0] !== 1'b1 || o_gnt[1] !== 1'b1) begin errors++; $display("FAIL wr_rd_gnt: got %b%b expected 11", o_gnt[0], o_gnt[1]); end
        checks++; if (o_valid[LAT-1] !== 1'b0) begin errors++; $display("FAIL wr_rd_early_valid: got %b expected 0", o_valid[LAT-1]); end
        checks++; if (o_valid[LAT] !== 1'b1 || o_id[LAT] !== 20'd3) begin errors++; $display("FAIL wr_rsp: valid %b id %h expected 1 3", o_valid[LAT], o_id[LAT]); end
        checks++; if (o_valid[1+LAT] !== 1'b1 || o_id[1+LAT] !== 20'd7) begin errors++; $display("FAIL rd_rsp: valid %b id %h expected 1 7", o_valid[1+LAT], o_id[1+LAT]); end
        checks++; if (o_data[1+LAT] !== 32'hCAFE0001) begin errors++; $display("FAIL rd_data: got %h expected cafe0001", o_data[1+LAT]); end
        checks++; if (o_valid[2+LAT] !== 1'b0) begin errors++; $display("FAIL wr_rd_extra_valid: got %b expected 0", o_valid[2+LAT]); end
    endtask

    task automatic test_ts();
        seq.push_back(mk(1, 0, 0, 32'h80, 32'h0, 4'hF, 20'd1));
        seq.push_back(mk(1, 1, 1, 32'h80, 32'h0, 4'hF, 20'd5));
        add_idle(1);
        seq.push_back(mk(1, 1, 0, 32'h80, 32'h0, 4'hF, 20'd6));
        add_idle(3);
        run_seq();
        checks++; if (o_gnt[1] !== 1'b1 || o_gnt[2] !== 1'b0 || o_gnt[3] !== 1'b1) begin errors++; $display("FAIL ts_gnt: got %b%b%b expected 101", o_gnt[1], o_gnt[2], o_gnt[3]); end
        checks++; if (o_sw[2] !== 1'b1 || o_add[2] !== 30'h20) begin errors++; $display("FAIL ts_wb_strobe: we %b add %h expected 1 20", o_sw[2], o_add[2]); end
        checks++; if (o_valid[1+LAT] !== 1'b1 || o_data[1+LAT] !== 32'h0 || o_id[1+LAT] !== 20'd5) begin errors++; $display("FAIL ts_rsp: valid %b data %h id %h expected 1 0 5", o_valid[1+LAT], o_data[1+LAT], o_id[1+LAT]); end
        checks++; if (o_valid[2+LAT] !== 1'b0) begin errors++; $display("FAIL ts_wb_no_rsp: got %b expected 0", o_valid[2+LAT]); end
        checks++; if (o_valid[3+LAT] !== 1'b1 || o_data[3+LAT] !== 32'hFFFFFFFF || o_id[3+LAT] !== 20'd6) begin errors++; $display("FAIL ts_after_read: valid %b data %h id %h expected 1 ffffffff 6", o_valid[3+LAT], o_data[3+LAT], o_id[3+LAT]); end
    endtask

    task automatic test_ts_contention();
        seq.push_back(mk(1, 1, 1, 32'h80, 32'h0, 4'hF, 20'd5));
        seq.push_back(mk(1, 1, 0, 32'h84, 32'h0, 4'hF, 20'd9));
        seq.push_back(mk(1, 1, 0, 32'h84, 32'h0, 4'hF, 20'd9));
        add_idle(3);
        run_seq();
        checks++; if (o_gnt[1] !== 1'b0 || o_gnt[2] !== 1'b1) begin errors++; $display("FAIL cont_gnt: got %b%b expected 01", o_gnt[1], o_gnt[2]); end
        checks++; if (o_valid[LAT] !== 1'b1 || o_data[LAT] !== 32'hFFFFFFFF || o_id[LAT] !== 20'd5) begin errors++; $display("FAIL cont_ts_rsp: valid %b data %h id %h expected 1 ffffffff 5", o_valid[LAT], o_data[LAT], o_id[LAT]); end
        checks++; if (o_valid[1+LAT] !== 1'b0) begin errors++; $display("FAIL cont_wb_rsp: got %b expected 0", o_valid[1+LAT]); end
        checks++; if (o_valid[2+LAT] !== 1'b1 || o_id[2+LAT] !== 20'd9 || o_data[2+LAT] !== 32'h0) begin errors++; $display("FAIL cont_b_rsp: valid %b id %h data %h expected 1 9 0", o_valid[2+LAT], o_id[2+LAT], o_data[2+LAT]); end
    endtask

    task automatic test_byte_enable();
        seq.push_back(mk(1, 0, 0, 32'h100, 32'h0, 4'hF, 20'd2));
        seq.push_back(mk(1, 0, 0, 32'h100, 32'h11223344, 4'b0101, 20'd3));
        seq.push_back(mk(1, 1, 0, 32'h100, 32'h0, 4'hF, 20'd4));
        add_idle(3);
        run_seq();
        checks++; if (o_valid[2+LAT] !== 1'b1 || o_data[2+LAT] !== 32'h00220044) begin errors++; $display("FAIL be_readback: valid %b data %h expected 1 00220044", o_valid[2+LAT], o_data[2+LAT]); end
    endtask

    task automatic test_reset_in_ts();
        req_t r;
        seq.push_back(mk(1, 0, 0, 32'hC0, 32'h12345678, 4'hF, 20'd1));
        seq.push_back(mk(1, 1, 1, 32'hC0, 32'h0, 4'hF, 20'd4));
        r = mk(0, 1, 0, 0, 0, 0, 0);
        r.rst = 1'b1;
        seq.push_back(r);
        seq.push_back(mk(1, 1, 0, 32'hC0, 32'h0, 4'hF, 20'd8));
        add_idle(3);
        run_seq();
        checks++; if (o_sw[2] !== 1'b0) begin errors++; $display("FAIL rst_wb_strobe: got %b expected 0", o_sw[2]); end
        checks++; if (o_gnt[3] !== 1'b1 || o_valid[3] !== 1'b0 || o_id[3] !== '0) begin errors++; $display("FAIL rst_after: gnt %b valid %b id %h expected 1 0 0", o_gnt[3], o_valid[3], o_id[3]); end
        checks++; if (o_valid[3+LAT] !== 1'b1 || o_data[3+LAT] !== 32'h12345678 || o_id[3+LAT] !== 20'd8) begin errors++; $display("FAIL rst_keep_word: valid %b data %h id %h expected 1 12345678 8", o_valid[3+LAT], o_data[3+LAT], o_id[3+LAT]); end
    endtask

    task automatic test_random();
        req_t e;
        for (int i = 0; i < 400; i++) begin
            e = mk($urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 3) == 0,
                   {26'h0, 3'($urandom_range(0, 7)), 2'b00, 1'b0} | 32'($urandom_range(0, 3)),
                   $urandom, 4'($urandom), 20'($urandom));
            @(posedge clk); #1;
            drive(e);
        end
        @(posedge clk); #1;
        drive(mk(0, 1, 0, 0, 0, 0, 0));
        repeat (LAT + 3) @(negedge clk);
    endtask

    initial begin
        drive(mk(0, 1, 0, 0, 0, 0, 0));
        rst = 1'b1;
        test_reset();
        test_write_read();
        test_ts();
        test_ts_contention();
        test_byte_enable();
        test_reset_in_ts();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
